// File: rtl/dino_pkg.sv
// Shared state encoding and geometry defaults for the dino runner sequencer and its renderer.
// The per-pixel draw and collision code import these so both sides agree on sizes.
package dino_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } game_state_t;

   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_GROUND_Y = 400;
   localparam int DEF_DINO_X_R = 250;
   localparam int DEF_DINO_W   = 40;
   localparam int DEF_DINO_H   = 60;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/dino_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4); one step per clock, output is the register.
// No handshake; from the nonzero seed the maximal-length sequence never reaches all-zero.
module dino_lfsr8
   import dino_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= LFSR_SEED;
      end else begin
         q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
      end
   end

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino runner sequencer: game FSM, jump physics, obstacle scroll/respawn, speed ramp, score, collision.
// frame_tick at T shows new geometry at T+1; a hit seen at T+1 reaches OVER at T+2. No backpressure.
module dino_game_ctrl
   import dino_pkg::*;
#(
   parameter int SCREEN_W   = DEF_SCREEN_W,
   parameter int GROUND_Y   = DEF_GROUND_Y,
   parameter int DINO_X_R   = DEF_DINO_X_R,
   parameter int DINO_W     = DEF_DINO_W,
   parameter int DINO_H     = DEF_DINO_H,
   parameter int OBST_W     = 20,
   parameter int OBST_H_LO  = 40,
   parameter int OBST_H_HI  = 60,
   parameter int JUMP_V0    = 16,
   parameter int SPEED_INIT = 4,
   parameter int SPEED_MAX  = 12,
   parameter int SPEED_STEP = 10
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        btn_start,
   input  logic        btn_jump,
   output logic [9:0]  dino_top,
   output logic [9:0]  obst_r,
   output logic [6:0]  obst_h,
   output logic [13:0] score,
   output logic [3:0]  speed,
   output logic [1:0]  state,
   output logic        gameover
);

   localparam logic [9:0]        OBST_R_INIT = 10'(SCREEN_W - 1);
   localparam logic [9:0]        DINO_TOP_0  = 10'(GROUND_Y - DINO_H);
   localparam logic [9:0]        HIT_LEFT    = 10'(DINO_X_R - DINO_W);
   localparam logic [9:0]        HIT_RIGHT   = 10'(DINO_X_R + OBST_W);
   localparam logic [6:0]        H_LO        = 7'(OBST_H_LO);
   localparam logic [6:0]        H_HI        = 7'(OBST_H_HI);
   localparam logic [7:0]        JUMP_H      = 8'(JUMP_V0);
   localparam logic signed [5:0] JUMP_VEL    = 6'(JUMP_V0 - 1);
   localparam logic [13:0]       SCORE_MAX   = 14'd9999;
   localparam logic [3:0]        SPD_INIT    = 4'(SPEED_INIT);
   localparam logic [3:0]        SPD_MAX     = 4'(SPEED_MAX);
   localparam logic [3:0]        STEP_LAST   = 4'(SPEED_STEP - 1);

   game_state_t        state_q, state_nx;
   logic               start_q;
   logic [7:0]         dino_h, dino_h_nx;
   logic signed [5:0]  vel, vel_nx;
   logic [9:0]         obst_r_nx;
   logic [6:0]         obst_h_nx;
   logic [13:0]        score_nx;
   logic [3:0]         speed_nx;
   logic [3:0]         step_cnt, step_nx;
   logic               load_init;
   logic [7:0]         lfsr_q;
   logic               lfsr_unused;

   logic        start_rise;
   logic        grounded;
   logic [9:0]  h_sum;
   logic        horiz, vert, hit;

   dino_lfsr8 u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   assign lfsr_unused = ^lfsr_q[7:1];

   assign start_rise = btn_start & ~start_q;
   assign grounded   = (dino_h == 8'd0) && (vel == 6'sd0);
   // Signed sum in 10 bits: bit 9 set means the dino would end below ground.
   assign h_sum      = {2'b00, dino_h} + {{4{vel[5]}}, vel};

   // Right-edge test against DINO_X_R+OBST_W avoids computing obst_r-OBST_W.
   assign horiz = (obst_r >= HIT_LEFT) && (obst_r <= HIT_RIGHT);
   assign vert  = dino_h < {1'b0, obst_h};
   assign hit   = (state_q == RUN) && horiz && vert;

   assign dino_top = DINO_TOP_0 - {2'b00, dino_h};
   assign state    = state_q;
   assign gameover = (state_q == OVER);

   always_comb begin
      state_nx  = state_q;
      dino_h_nx = dino_h;
      vel_nx    = vel;
      obst_r_nx = obst_r;
      obst_h_nx = obst_h;
      score_nx  = score;
      speed_nx  = speed;
      step_nx   = step_cnt;
      load_init = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_rise) begin
               state_nx  = RUN;
               load_init = 1'b1;
            end
         end
         RUN: begin
            if (hit) begin
               state_nx = OVER;
            end else if (frame_tick) begin
               if (grounded && btn_jump) begin
                  dino_h_nx = JUMP_H;
                  vel_nx    = JUMP_VEL;
               end else if (h_sum[9] || (h_sum == 10'd0)) begin
                  dino_h_nx = 8'd0;
                  vel_nx    = 6'sd0;
               end else begin
                  dino_h_nx = h_sum[7:0];
                  vel_nx    = vel - 6'sd1;
               end

               if (obst_r <= {6'd0, speed}) begin
                  obst_r_nx = OBST_R_INIT;
                  obst_h_nx = lfsr_q[0] ? H_HI : H_LO;
                  // step_cnt tracks score mod SPEED_STEP, so no divider is needed.
                  if (score != SCORE_MAX) begin
                     score_nx = score + 14'd1;
                     if (step_cnt == STEP_LAST) begin
                        step_nx = 4'd0;
                        if (speed < SPD_MAX) begin
                           speed_nx = speed + 4'd1;
                        end
                     end else begin
                        step_nx = step_cnt + 4'd1;
                     end
                  end
               end else begin
                  obst_r_nx = obst_r - {6'd0, speed};
               end
            end
         end
         OVER: begin
            if (start_rise) begin
               state_nx  = RUN;
               load_init = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (load_init) begin
         dino_h_nx = 8'd0;
         vel_nx    = 6'sd0;
         obst_r_nx = OBST_R_INIT;
         obst_h_nx = H_LO;
         score_nx  = 14'd0;
         speed_nx  = SPD_INIT;
         step_nx   = 4'd0;
      end
   end

   // start_q resets high so a button held through reset does not start a game.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         start_q  <= 1'b1;
         dino_h   <= 8'd0;
         vel      <= 6'sd0;
         obst_r   <= OBST_R_INIT;
         obst_h   <= H_LO;
         score    <= 14'd0;
         speed    <= SPD_INIT;
         step_cnt <= 4'd0;
      end else begin
         state_q  <= state_nx;
         start_q  <= btn_start;
         dino_h   <= dino_h_nx;
         vel      <= vel_nx;
         obst_r   <= obst_r_nx;
         obst_h   <= obst_h_nx;
         score    <= score_nx;
         speed    <= speed_nx;
         step_cnt <= step_nx;
      end
   end

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Scoreboarded bench for dino_game_ctrl: a cycle model pushes expected outputs per driven cycle,
// compared after the edge, plus fixed-value checks at the scenario milestones.
module tb_dino_game_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic        btn_start = 1'b1;
   logic        btn_jump = 1'b0;
   logic [9:0]  dino_top;
   logic [9:0]  obst_r;
   logic [6:0]  obst_h;
   logic [13:0] score;
   logic [3:0]  speed;
   logic [1:0]  state;
   logic        gameover;

   dino_game_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .btn_start  (btn_start),
      .btn_jump   (btn_jump),
      .dino_top   (dino_top),
      .obst_r     (obst_r),
      .obst_h     (obst_h),
      .score      (score),
      .speed      (speed),
      .state      (state),
      .gameover   (gameover)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int go;
      int top;
      int r;
      int oh;
      int sc;
      int sp;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   int m_state, m_h, m_vel, m_r, m_oh, m_score, m_speed, m_start_q;
   logic [7:0] m_lfsr;

   always @(posedge clk) begin
      if (rst) m_lfsr <= 8'hA5;
      else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_init();
      m_h = 0; m_vel = 0; m_r = 639; m_oh = 40; m_score = 0; m_speed = 4;
   endtask

   task automatic model_cycle(input logic r, input logic s, input logic t, input logic j);
      bit rise;
      bit hit;
      if (r) begin
         m_state = 0; m_start_q = 1; model_init();
         return;
      end
      rise = s && (m_start_q == 0);
      m_start_q = s;
      case (m_state)
         0: if (rise) begin m_state = 1; model_init(); end
         1: begin
            hit = (m_r >= 210) && (m_r <= 270) && (m_h < m_oh);
            if (hit) begin
               m_state = 2;
            end else if (t) begin
               if (m_h == 0 && m_vel == 0 && j) begin
                  m_h = 16; m_vel = 15;
               end else if (m_h + m_vel <= 0) begin
                  m_h = 0; m_vel = 0;
               end else begin
                  m_h = m_h + m_vel; m_vel = m_vel - 1;
               end
               if (m_r <= m_speed) begin
                  m_r  = 639;
                  m_oh = m_lfsr[0] ? 60 : 40;
                  if (m_score < 9999) m_score++;
                  if (m_score % 10 == 0 && m_score != 0 && m_speed < 12) m_speed++;
               end else begin
                  m_r = m_r - m_speed;
               end
            end
         end
         default: if (rise) begin m_state = 1; model_init(); end
      endcase
   endtask

   task automatic drive_cycle(input logic r, input logic s, input logic t, input logic j);
      exp_t e;
      rst = r; btn_start = s; frame_tick = t; btn_jump = j;
      model_cycle(r, s, t, j);
      e.st = m_state; e.go = (m_state == 2) ? 1 : 0; e.top = 340 - m_h;
      e.r = m_r; e.oh = m_oh; e.sc = m_score; e.sp = m_speed;
      sb_q.push_back(e);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      check_val("sb_state",    32'(state),    e.st);
      check_val("sb_gameover", 32'(gameover), e.go);
      check_val("sb_dino_top", 32'(dino_top), e.top);
      check_val("sb_obst_r",   32'(obst_r),   e.r);
      check_val("sb_obst_h",   32'(obst_h),   e.oh);
      check_val("sb_score",    32'(score),    e.sc);
      check_val("sb_speed",    32'(speed),    e.sp);
   endtask

   task automatic tick(input logic j);
      drive_cycle(1'b0, 1'b0, 1'b1, j);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Jump on the one tick where the obstacle sits in (270+4s, 270+5s]: airborne above 60 px across the window.
   task automatic play_until(input int target);
      bit jmp;
      for (int i = 0; i < 20000 && m_score < target && m_state == 1; i++) begin
         jmp = (m_h == 0) && (m_vel == 0) && (m_r > 270 + 4 * m_speed) && (m_r <= 270 + 5 * m_speed);
         tick(jmp);
      end
   endtask

   task automatic run_to_over();
      for (int i = 0; i < 400 && m_state == 1; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      m_state = 0; m_start_q = 1; model_init();

      repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check_val("rst_state",    32'(state),    0);
      check_val("rst_gameover", 32'(gameover), 0);
      check_val("rst_dino_top", 32'(dino_top), 340);
      check_val("rst_obst_r",   32'(obst_r),   639);
      check_val("rst_obst_h",   32'(obst_h),   40);
      check_val("rst_speed",    32'(speed),    4);

      repeat (3) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("held_start_idle", 32'(state), 0);
      repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("start_run", 32'(state), 1);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

      repeat (20) tick(1'b0);
      check_val("obst_r_20ticks", 32'(obst_r), 559);
      run_to_over();
      check_val("hit_state",    32'(state),    2);
      check_val("hit_gameover", 32'(gameover), 1);
      check_val("hit_obst_r",   32'(obst_r),   267);

      repeat (5) tick(1'b0);
      check_val("over_frozen_r",  32'(obst_r), 267);
      check_val("over_frozen_st", 32'(state),  2);
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("restart_state", 32'(state),  1);
      check_val("restart_obst",  32'(obst_r), 639);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

      for (int k = 1; k <= 33; k++) begin
         tick(k == 1 || k == 10);
         if (k == 1)  check_val("jump_t1",   32'(dino_top), 324);
         if (k == 2)  check_val("jump_t2",   32'(dino_top), 309);
         if (k == 5) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
            check_val("start_in_run", 32'(state), 1);
         end
         if (k == 16) check_val("jump_peak", 32'(dino_top), 204);
         if (k == 32) check_val("jump_t32",  32'(dino_top), 324);
         if (k == 33) check_val("jump_land", 32'(dino_top), 340);
      end

      play_until(10);
      check_val("score10",       32'(score), 10);
      check_val("speed_at_10",   32'(speed), 5);
      play_until(80);
      check_val("score80",       32'(score), 80);
      check_val("speed_at_80",   32'(speed), 12);
      play_until(90);
      check_val("score90",       32'(score), 90);
      check_val("speed_at_90",   32'(speed), 12);

      run_to_over();
      check_val("over2_state", 32'(state), 2);
      repeat (5) tick(1'b0);
      check_val("over2_score_held", 32'(score),    90);
      check_val("over2_gameover",   32'(gameover), 1);
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("restart2_state", 32'(state),  1);
      check_val("restart2_score", 32'(score),  0);
      check_val("restart2_speed", 32'(speed),  4);
      check_val("restart2_obst",  32'(obst_r), 639);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

      tick(1'b1);
      repeat (4) tick(1'b0);
      check_val("midjump_top", 32'(dino_top), 270);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("midrst_state",    32'(state),    0);
      check_val("midrst_gameover", 32'(gameover), 0);
      check_val("midrst_dino_top", 32'(dino_top), 340);
      check_val("midrst_obst_r",   32'(obst_r),   639);
      check_val("midrst_speed",    32'(speed),    4);
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check_val("idle_after_rst",  32'(state),    0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dino_game_ctrl.md
# dino_game_ctrl

Game sequencer for the dinosaur runner. It holds the game state machine, dinosaur jump physics, obstacle scroll and respawn, speed ramp, score counter, and a per-frame bounding-box collision check. Outputs are registered geometry and status, which the VGA pixel renderer and score display consume. The renderer draws from these values and makes no gameplay decisions.

## Interface
Parameters:
- SCREEN_W, 640: visible width; obstacle respawns with right edge at SCREEN_W-1.
- GROUND_Y, 400: row of ground line (bottom of dino and obstacle).
- DINO_X_R, 250: dino right-edge column.
- DINO_W, 40 / DINO_H, 60: dino box size.
- OBST_W, 20: obstacle width.
- OBST_H_LO, 40 / OBST_H_HI, 60: the two obstacle heights.
- JUMP_V0, 16: initial upward velocity, px/frame.
- SPEED_INIT, 4 / SPEED_MAX, 12: obstacle px/frame.
- SPEED_STEP, 10: points per speed increment.

Ports:
- clk  in  1  system clock (VGA pixel clock domain).
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (end of visible area).
- btn_start  in  1  debounced level; rising edge starts or restarts.
- btn_jump  in  1  debounced level; sampled on frame_tick.
- dino_top  out  10  row of dino top edge = GROUND_Y-DINO_H-dino_h.
- obst_r  out  10  obstacle right-edge column.
- obst_h  out  7  current obstacle height.
- score  out  14  obstacles cleared, binary, saturates at 9999.
- speed  out  4  current scroll speed.
- state  out  2  IDLE=0, RUN=1, OVER=2.
- gameover  out  1  high exactly while state==OVER.

## Operation
- Start edge detection: `start_q` registers btn_start and resets to 1, so a button held through reset does not start a game. `start_rise = btn_start & ~start_q`.
- IDLE: outputs hold their init values.
  - Init values: dino_h=0, vel=0, obst_r=SCREEN_W-1, obst_h=OBST_H_LO, score=0, speed=SPEED_INIT.
  - start_rise → RUN.
- RUN, on frame_tick (single-cycle update):
  - Jump: if grounded (dino_h==0, vel==0) and btn_jump=1, then dino_h←JUMP_V0 and vel←JUMP_V0-1.
  - Airborne: if dino_h+vel ≤ 0, then dino_h←0 and vel←0 (landing). Otherwise dino_h←dino_h+vel and vel←vel-1.
  - vel is signed 6-bit; dino_h is unsigned 8-bit. Peak height = JUMP_V0·(JUMP_V0+1)/2 = 136.
  - Obstacle: if obst_r ≤ speed, respawn.
    - Respawn sets obst_r←SCREEN_W-1, score←min(score+1, 9999), and obst_h←OBST_H_HI if lfsr[0] else OBST_H_LO.
    - If the new score is a nonzero multiple of SPEED_STEP and speed<SPEED_MAX, speed←speed+1.
  - Otherwise obst_r←obst_r-speed.
- Collision: evaluated every RUN cycle on the registered values. hit = horizontal & vertical, where:
  - horizontal = (obst_r ≥ DINO_X_R-DINO_W) && (obst_r ≤ DINO_X_R+OBST_W). The second term avoids an obst_r-OBST_W underflow.
  - vertical = dino_h < obst_h. Touching edges is not a hit.
  - hit → OVER; all geometry and score freeze.
- OVER: frame_tick is ignored. start_rise → RUN with every variable reloaded to its init value in the same transition. score is cleared at that point and not earlier.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Seeded 8'hA5 on rst; advances every clock so obstacle choice depends on press timing; never all-zero.

## Timing
- Reset values: state=IDLE, gameover=0, dino_top=GROUND_Y-DINO_H (340), obst_r=639, obst_h=40, score=0, speed=4.
- start_rise sampled at cycle T → state=RUN at T+1.
- frame_tick at T → updated geometry visible at T+1. A hit is detected at T+1 → state=OVER and gameover=1 at T+2.
- If frame_tick arrives in the same cycle as hit=1, the hit wins and no update occurs.
- btn_start edges in RUN are ignored.
- rst in any state overrides everything on the next edge.
- obst_r never underflows: the respawn check precedes the subtract.

## Structure
- Package `dino_pkg` holds:
  - the state enum (IDLE/RUN/OVER);
  - geometry defaults (GROUND_Y, DINO_X_R, DINO_W, DINO_H, SCREEN_W);
  - the LFSR seed.
- The colli per-pixel check and renderer import the same constants.
- One sub-module: `dino_lfsr8` (clk, rst, q[7:0]).

## Test plan
- Reset with btn_start held high, then release and press once → state stays IDLE until the press; RUN one cycle after the rising edge; dino_top=340, obst_r=639.
- RUN, no jump, 20 frame_ticks at speed 4 → obst_r=559. No hit until obst_r enters 210..270, then state=OVER two cycles after that tick and gameover=1.
- btn_jump held for 1 tick from ground → dino_h sequence 16,31,45…136 peak, then back to 0 after 32 ticks total. A second press mid-air has no effect.
- Force 10 respawns (jump over each) → score=10, speed=5. At score 80, speed=12, and it stays 12 at 90.
- In OVER, pulse frame_tick ×5 → all outputs frozen. start_rise → RUN next cycle with score=0, speed=4, obst_r=639.
- Assert rst mid-jump in RUN → next cycle all outputs at reset values, state=IDLE.
